// File: rtl/ecc_20_wr_enc_if.sv
// Upstream word handshake and memory write port of the ECC write encoder.
interface ecc_20_wr_enc_if #(parameter int ADDR_WIDTH = 4);
   logic                  in_valid;
   logic                  in_ready;
   logic [19:0]           in_data;
   logic                  bypass;
   logic                  mem_full;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [19:0]           mem_wdata;
   logic [5:0]            mem_wparity;

   modport master (
      output in_valid, in_data, bypass, mem_full,
      input  in_ready, mem_we, mem_waddr, mem_wdata, mem_wparity
   );

   modport slave (
      input  in_valid, in_data, bypass, mem_full,
      output in_ready, mem_we, mem_waddr, mem_wdata, mem_wparity
   );
endinterface

// File: rtl/ecc_20_wr_enc.sv
// 20-bit ECC write encoder: one output stage, sequential write address,
// armed single/double bit error injection into the stored codeword.
module ecc_20_wr_enc #(
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ecc_20_wr_enc_if.slave       bus,
   input  logic                 inj_sbit,
   input  logic                 inj_dbit,
   input  logic [4:0]           inj_pos,
   output logic                 inj_done,
   output logic [CNT_WIDTH-1:0] wr_cnt
);
   typedef enum logic [1:0] {IDLE, ARM_S, ARM_D} inj_state_t;

   inj_state_t            state;
   logic [4:0]            arm_pos;
   logic                  s_valid;
   logic                  s_inj;
   logic [25:0]           s_cw;
   logic [ADDR_WIDTH-1:0] waddr;

   logic        accept, write;
   logic        use_inj, use_dbl;
   logic [4:0]  use_pos;
   logic [25:0] flip, clean_cw;

   function automatic logic [5:0] calc_par(input logic [19:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15]^d[17]^d[19];
      p[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13]^d[16]^d[17];
      p[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15]^d[16]^d[17];
      p[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10]^d[18]^d[19];
      p[4] = ^d[19:11];
      p[5] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[12]^d[14]^d[17]^d[18];
      return p;
   endfunction

   assign bus.in_ready = !s_valid || !bus.mem_full;
   assign accept       = bus.in_valid && bus.in_ready;
   assign write        = s_valid && !bus.mem_full;

   assign bus.mem_we      = write;
   assign bus.mem_waddr   = waddr;
   assign bus.mem_wdata   = s_cw[19:0];
   assign bus.mem_wparity = s_cw[25:20];
   assign inj_done        = write && s_inj;

   // Parity is taken from the clean payload; the flip mask is applied afterwards.
   assign clean_cw = {(bus.bypass ? 6'b000000 : calc_par(bus.in_data)), bus.in_data};

   // An arm request in the accepting cycle takes effect on that very word.
   always_comb begin
      use_inj = 1'b1;
      use_dbl = inj_dbit;
      use_pos = inj_pos;
      if (!(inj_sbit || inj_dbit)) begin
         use_inj = (state != IDLE);
         use_dbl = (state == ARM_D);
         use_pos = arm_pos;
      end
      flip = '0;
      if (use_inj && (use_pos < 5'd26)) begin
         flip[use_pos] = 1'b1;
         if (use_dbl) flip[(use_pos == 5'd25) ? 5'd0 : use_pos + 5'd1] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid <= 1'b0;
         s_inj   <= 1'b0;
         s_cw    <= '0;
         waddr   <= '0;
         wr_cnt  <= '0;
      end else begin
         if (accept) begin
            s_valid <= 1'b1;
            s_cw    <= clean_cw ^ flip;
            s_inj   <= use_inj;
         end else if (write) begin
            s_valid <= 1'b0;
         end
         if (write) begin
            waddr  <= waddr + 1'b1;
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         arm_pos <= '0;
      end else if (accept) begin
         state <= IDLE;
      end else if (inj_dbit) begin
         state   <= ARM_D;
         arm_pos <= inj_pos;
      end else if (inj_sbit) begin
         state   <= ARM_S;
         arm_pos <= inj_pos;
      end
   end
endmodule

// File: tb/tb_ecc_20_wr_enc.sv
// Scoreboard bench for ecc_20_wr_enc: stimulus pushes expected codewords,
// a monitor pops and compares on every memory write.
module tb_ecc_20_wr_enc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inj_sbit = 1'b0, inj_dbit = 1'b0;
   logic [4:0]  inj_pos = '0;
   logic        inj_done;
   logic [15:0] wr_cnt;

   ecc_20_wr_enc_if #(.ADDR_WIDTH(4)) bus();

   ecc_20_wr_enc #(.ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .inj_sbit(inj_sbit), .inj_dbit(inj_dbit), .inj_pos(inj_pos),
      .inj_done(inj_done), .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] d;
      logic [5:0]  p;
      logic        inj;
   } exp_t;

   exp_t q[$];
   int   nwr = 0;
   int   checks = 0, failures = 0;
   logic arm = 1'b0, arm_dbl = 1'b0;
   int   arm_pos = 0;

   // Data bits feeding each parity bit; -1 pads the shorter lists.
   int plist [6][12] = '{
      '{0, 1, 3, 4, 6, 8, 10, 11, 13, 15, 17, 19},
      '{0, 2, 3, 5, 6, 9, 10, 12, 13, 16, 17, -1},
      '{1, 2, 3, 7, 8, 9, 10, 14, 15, 16, 17, -1},
      '{4, 5, 6, 7, 8, 9, 10, 18, 19, -1, -1, -1},
      '{11, 12, 13, 14, 15, 16, 17, 18, 19, -1, -1, -1},
      '{0, 1, 2, 4, 5, 7, 10, 11, 12, 14, 17, 18}
   };

   function automatic logic [5:0] ref_par(input logic [19:0] d);
      logic [5:0] p = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 12; j++)
            if (plist[i][j] >= 0) p[i] = p[i] ^ d[plist[i][j]];
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: drive at +2 after the edge, check and model at +3.
   task automatic cyc(input logic v, input logic [19:0] d, input logic byp,
                      input logic sb, input logic db, input logic [4:0] pos,
                      input logic full);
      bit         occ, rdy;
      logic [25:0] cw;
      int          k;
      @(posedge clk);
      #2;
      bus.in_valid = v; bus.in_data = d; bus.bypass = byp; bus.mem_full = full;
      inj_sbit = sb; inj_dbit = db; inj_pos = pos;
      #1;
      occ = (q.size() != 0);
      rdy = !occ || !full;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      chk("mem_we", 32'(bus.mem_we), 32'(occ && !full));
      chk("mem_waddr", 32'(bus.mem_waddr), 32'(nwr % 16));
      chk("wr_cnt", 32'(wr_cnt), 32'(nwr % 65536));
      if (occ) begin
         chk("stage_data", 32'(bus.mem_wdata), 32'(q[0].d));
         chk("stage_par", 32'(bus.mem_wparity), 32'(q[0].p));
         chk("inj_done", 32'(inj_done), 32'(q[0].inj && !full));
      end else begin
         chk("inj_done_idle", 32'(inj_done), 32'(0));
      end
      if (db) begin arm = 1'b1; arm_dbl = 1'b1; arm_pos = int'(pos); end
      else if (sb) begin arm = 1'b1; arm_dbl = 1'b0; arm_pos = int'(pos); end
      if (v && rdy) begin
         exp_t e;
         cw = {(byp ? 6'b000000 : ref_par(d)), d};
         e.inj = arm;
         if (arm) begin
            k = arm_pos;
            if (k < 26) begin
               cw[k] = ~cw[k];
               if (arm_dbl) cw[(k + 1) % 26] = ~cw[(k + 1) % 26];
            end
            arm = 1'b0;
         end
         e.d = cw[19:0];
         e.p = cw[25:20];
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.bypass = 1'b0; bus.mem_full = 1'b0;
      inj_sbit = 1'b0; inj_dbit = 1'b0; inj_pos = '0;
      q.delete();
      nwr = 0;
      arm = 1'b0;
      #1;
      chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
      chk("rst_waddr", 32'(bus.mem_waddr), 32'(0));
      chk("rst_wdata", 32'(bus.mem_wdata), 32'(0));
      chk("rst_wparity", 32'(bus.mem_wparity), 32'(0));
      chk("rst_wr_cnt", 32'(wr_cnt), 32'(0));
      chk("rst_inj_done", 32'(inj_done), 32'(0));
      chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: every write must match the oldest expected word, in order.
   always @(posedge clk) begin
      #4;
      if (rst_n && bus.mem_we === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h expected=none", bus.mem_wdata);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mon_data", 32'(bus.mem_wdata), 32'(e.d));
            chk("mon_par", 32'(bus.mem_wparity), 32'(e.p));
            chk("mon_inj_done", 32'(inj_done), 32'(e.inj));
            chk("mon_addr", 32'(bus.mem_waddr), 32'(nwr % 16));
         end
         nwr++;
      end
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.bypass = 1'b0; bus.mem_full = 1'b0;
      do_reset();

      // Basic parity vectors, including bypass.
      cyc(1'b1, 20'h00001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      cyc(1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("v1_we", 32'(bus.mem_we), 32'(1));
      chk("v1_addr", 32'(bus.mem_waddr), 32'(0));
      chk("v1_par", 32'(bus.mem_wparity), 32'(6'b100011));
      cyc(1'b1, 20'hFFFFF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("ones_par", 32'(bus.mem_wparity), 32'(6'b011110));
      idle(1);
      chk("bypass_par", 32'(bus.mem_wparity), 32'(6'b000000));

      // Single-bit injection armed ahead of the word, then a clean word.
      cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
      cyc(1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      cyc(1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("sbit_data", 32'(bus.mem_wdata), 32'(20'h00008));
      chk("sbit_par", 32'(bus.mem_wparity), 32'(0));
      chk("sbit_done", 32'(inj_done), 32'(1));
      idle(1);
      chk("clean_done", 32'(inj_done), 32'(0));
      chk("clean_data", 32'(bus.mem_wdata), 32'(0));

      // Double-bit wrap from the top parity bit, armed in the accept cycle.
      cyc(1'b1, 20'h00000, 1'b0, 1'b0, 1'b1, 5'd25, 1'b0);
      idle(1);
      chk("dbit_data", 32'(bus.mem_wdata), 32'(20'h00001));
      chk("dbit_par", 32'(bus.mem_wparity), 32'(6'b100000));

      // Backpressure: word held for 5 cycles while a new one waits.
      cyc(1'b1, 20'h12345, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 20'hABCDE, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      cyc(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(2);

      // Reset with a staged word and an armed injection pending.
      cyc(1'b1, 20'h0F0F0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      cyc(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1);
      do_reset();
      cyc(1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(1);
      chk("post_rst_data", 32'(bus.mem_wdata), 32'(0));
      chk("post_rst_done", 32'(inj_done), 32'(0));

      // 17 back-to-back writes: address wraps to 0, counter reaches 17.
      do_reset();
      for (int i = 0; i < 17; i++) cyc(1'b1, 20'($urandom), 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle(2);
      chk("b2b_wr_cnt", 32'(wr_cnt), 32'(17));
      chk("b2b_waddr", 32'(bus.mem_waddr), 32'(1));

      // Randomized traffic.
      for (int i = 0; i < 800; i++)
         cyc(($urandom_range(0, 9) < 7), 20'($urandom), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
             5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));

      // Drain with a bounded wait.
      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
      idle(1);
      chk("drain_empty", 32'(q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
